weight_loader: RTL and testbench
================================

# weight_loader

Sequential programming master for the spiking layer's weight-memory port. Accepts a valid/ready stream of weight words, writes them to every neuron's weight RAM in {neuron, weight} address order, and optionally reads each word back to verify it. Sits between the host/DMA weight source and the layer's mem_addr/mem_din/mem_wen/mem_dout port, and drives that port exclusively while busy.

## Interface
- WEIGHT_SIZE, 32, weight word width
- NUM_INPUTS, 4, weights per neuron (1 ≤ NUM_INPUTS ≤ 2^WEIGHT_ADDR_WIDTH)
- NUM_NEURONS, 1, neurons in target layer (≥1, must fit in NEURON_ADDR_WIDTH−WEIGHT_ADDR_WIDTH bits)
- NEURON_ADDR_WIDTH, 28, full mem_addr width
- WEIGHT_ADDR_WIDTH, 10, low address bits selecting weight within a neuron
- VERIFY, 1, 1 = read-after-write check per word; 0 = write only
- RD_LAT, 1, target memory read latency in cycles (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a full load; ignored while busy
- s_valid  in  1  weight word available
- s_ready  out  1  loader accepts word this cycle
- s_data  in  WEIGHT_SIZE  weight word
- mem_addr  out  NEURON_ADDR_WIDTH  {neuron index, weight index}, zero-extended fields
- mem_din  out  WEIGHT_SIZE  write data
- mem_wen  out  1  write enable, one cycle per word
- mem_dout  in  WEIGHT_SIZE  read data from layer
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at load completion
- error  out  1  sticky: any verify mismatch in current/last load
- err_count  out  16  mismatch count, saturates at 16'hFFFF
- err_addr  out  NEURON_ADDR_WIDTH  address of first mismatch

## Operation
- States: IDLE, ACCEPT, WRITE, CHECK, DONE.
- IDLE: start=1 → clear error, err_count, err_addr, word counters; busy=1; → ACCEPT.
- ACCEPT: s_ready=1. On s_valid: capture s_data; load mem_addr = (neuron_idx << WEIGHT_ADDR_WIDTH) | weight_idx, mem_din = s_data; → WRITE. No s_valid → stay.
- WRITE: mem_wen=1 for exactly this cycle; addr/din stable. → CHECK if VERIFY, else advance.
- CHECK: mem_wen=0, mem_addr held, lasts RD_LAT+1 cycles; on last cycle compare mem_dout with captured word. Mismatch: error=1, err_count+1 (saturating), err_addr latched only if err_count was 0. Then advance.
- Advance: weight_idx+1; at NUM_INPUTS−1 wrap to 0 and neuron_idx+1. After word NUM_NEURONS·NUM_INPUTS−1 → DONE, else → ACCEPT.
- DONE: done=1 one cycle, busy=0 on exit → IDLE. error/err_count/err_addr hold until next start.
- s_ready is 0 in every state except ACCEPT; extra stream words are not consumed.
- start during busy: ignored, no effect on counters.

## Timing
- Reset (async assert, sync release): state IDLE; s_ready, mem_wen, busy, done, error = 0; mem_addr, mem_din, err_count, err_addr = 0. Reset mid-load drops mem_wen immediately; partial load is abandoned, no done.
- All outputs registered.
- Per word with s_valid held high: VERIFY=0 → 2 cycles (ACCEPT, WRITE); VERIFY=1 → 3+RD_LAT cycles.
- Full load, s_valid always high: N·2 (+1 DONE) or N·(3+RD_LAT) (+1 DONE) cycles after start, N = NUM_NEURONS·NUM_INPUTS.
- Compare never occurs in the WRITE cycle (no read-during-write dependence).
- busy rises the cycle after start; done coincides with busy's last high cycle.

## Test plan
- NUM_NEURONS=2, NUM_INPUTS=4, VERIFY=1, RD_LAT=1, behavioural RAM, words 0x10..0x17 → writes at addr 0x000..0x003, 0x400..0x403 in order, 8 mem_wen pulses, done at cycle 33, error=0.
- Same config, s_valid toggled every other cycle → identical write sequence, s_ready only in ACCEPT, no word lost or duplicated.
- RAM model corrupts write to addr 0x402 (and 0x403) → error=1, err_count=2, err_addr=0x402, load still completes with done.
- VERIFY=0, NUM_NEURONS=1, NUM_INPUTS=4 → mem_wen every 2nd cycle, done 9 cycles after start, mem_dout ignored.
- Assert rst low after 3rd write → mem_wen, busy, s_ready go 0 asynchronously; after release new start reloads from addr 0.
- Pulse start mid-load → no restart, counters/addresses continue; start after done clears error and err_count.

Source files
------------

// File: rtl/weight_loader.sv
// weight_loader: programming master for the layer weight-memory port.
// Streams weight words into every neuron's weight RAM in {neuron, weight}
// address order and, when VERIFY is set, reads each word back and compares.
module weight_loader #(
  parameter int unsigned WEIGHT_SIZE       = 32,
  parameter int unsigned NUM_INPUTS        = 4,
  parameter int unsigned NUM_NEURONS       = 1,
  parameter int unsigned NEURON_ADDR_WIDTH = 28,
  parameter int unsigned WEIGHT_ADDR_WIDTH = 10,
  parameter int unsigned VERIFY            = 1,
  parameter int unsigned RD_LAT            = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [WEIGHT_SIZE-1:0]       s_data,
  output logic [NEURON_ADDR_WIDTH-1:0] mem_addr,
  output logic [WEIGHT_SIZE-1:0]       mem_din,
  output logic                         mem_wen,
  input  logic [WEIGHT_SIZE-1:0]       mem_dout,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [15:0]                  err_count,
  output logic [NEURON_ADDR_WIDTH-1:0] err_addr
);

  localparam int unsigned NIDX_W = NEURON_ADDR_WIDTH - WEIGHT_ADDR_WIDTH;
  localparam int unsigned CHK_W  = $clog2(RD_LAT + 1);

  localparam logic [WEIGHT_ADDR_WIDTH-1:0] LAST_W   = WEIGHT_ADDR_WIDTH'(NUM_INPUTS - 1);
  localparam logic [NIDX_W-1:0]            LAST_N   = NIDX_W'(NUM_NEURONS - 1);
  localparam logic [CHK_W-1:0]             CHK_LAST = CHK_W'(RD_LAT);

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, CHECK, DONE} state_t;

  state_t                       state_q;
  state_t                       state_d;
  logic [WEIGHT_ADDR_WIDTH-1:0] weight_idx;
  logic [NIDX_W-1:0]            neuron_idx;
  logic [CHK_W-1:0]             chk_cnt;
  logic                         last_c;
  logic                         clear_c;
  logic                         accept_c;
  logic                         advance_c;
  logic                         compare_c;

  // Current word is the final one of the whole load.
  assign last_c = (weight_idx == LAST_W) && (neuron_idx == LAST_N);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic and single-cycle datapath strobes.
  always_comb begin
    state_d   = state_q;
    clear_c   = 1'b0;
    accept_c  = 1'b0;
    advance_c = 1'b0;
    compare_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clear_c = 1'b1;
          state_d = ACCEPT;
        end
      end
      ACCEPT: begin
        if (s_valid) begin
          accept_c = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (VERIFY != 0) begin
          state_d = CHECK;
        end else begin
          advance_c = 1'b1;
          state_d   = last_c ? DONE : ACCEPT;
        end
      end
      CHECK: begin
        if (chk_cnt == CHK_LAST) begin
          compare_c = 1'b1;
          advance_c = 1'b1;
          state_d   = last_c ? DONE : ACCEPT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs registered from the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready <= 1'b0;
      mem_wen <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      s_ready <= (state_d == ACCEPT);
      mem_wen <= (state_d == WRITE);
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
    end
  end

  // Word capture, address counters and read-back wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      weight_idx <= '0;
      neuron_idx <= '0;
      chk_cnt    <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      chk_cnt <= (state_q == CHECK) ? chk_cnt + CHK_W'(1) : '0;
      if (clear_c) begin
        weight_idx <= '0;
        neuron_idx <= '0;
      end
      if (accept_c) begin
        mem_addr <= {neuron_idx, weight_idx};
        mem_din  <= s_data;
      end
      if (advance_c) begin
        if (weight_idx == LAST_W) begin
          weight_idx <= '0;
          neuron_idx <= neuron_idx + NIDX_W'(1);
        end else begin
          weight_idx <= weight_idx + WEIGHT_ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Verify status: sticky flag, saturating count, first failing address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error     <= 1'b0;
      err_count <= '0;
      err_addr  <= '0;
    end else if (clear_c) begin
      error     <= 1'b0;
      err_count <= '0;
      err_addr  <= '0;
    end else if (compare_c && (mem_dout != mem_din)) begin
      error <= 1'b1;
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (err_count == 16'd0)    err_addr  <= mem_addr;
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: a verify instance (2 neurons x 4 weights, RD_LAT=1)
// against a behavioural RAM, and a write-only instance (1 neuron x 4 weights).
module tb_weight_loader;

  localparam int unsigned WS = 32;
  localparam int unsigned AW = 28;
  localparam int unsigned NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_v, start_w, valid_v, valid_w;
  logic [WS-1:0] s_data, v_dout, w_dout;
  logic          v_ready, v_wen, v_busy, v_done, v_error;
  logic          w_ready, w_wen, w_busy, w_done, w_error;
  logic [AW-1:0] v_addr, v_err_addr, w_addr, w_err_addr;
  logic [WS-1:0] v_din, w_din;
  logic [15:0]   v_err_count, w_err_count;

  weight_loader #(.NUM_INPUTS(4), .NUM_NEURONS(2), .VERIFY(1), .RD_LAT(1)) u_v (
    .clk(clk), .rst(rst), .start(start_v), .s_valid(valid_v), .s_ready(v_ready),
    .s_data(s_data), .mem_addr(v_addr), .mem_din(v_din), .mem_wen(v_wen),
    .mem_dout(v_dout), .busy(v_busy), .done(v_done), .error(v_error),
    .err_count(v_err_count), .err_addr(v_err_addr));

  weight_loader #(.NUM_INPUTS(4), .NUM_NEURONS(1), .VERIFY(0), .RD_LAT(1)) u_w (
    .clk(clk), .rst(rst), .start(start_w), .s_valid(valid_w), .s_ready(w_ready),
    .s_data(s_data), .mem_addr(w_addr), .mem_din(w_din), .mem_wen(w_wen),
    .mem_dout(w_dout), .busy(w_busy), .done(w_done), .error(w_error),
    .err_count(w_err_count), .err_addr(w_err_addr));

  // Behavioural RAM with one-cycle read latency; optionally corrupts 0x402/0x403.
  logic [WS-1:0] ram [0:4095];
  bit            corrupt = 1'b0;
  always @(posedge clk) begin
    v_dout <= ram[v_addr[11:0]];
    if (v_wen)
      ram[v_addr[11:0]] <= (corrupt && (v_addr == 28'h402 || v_addr == 28'h403))
                           ? (v_din ^ 32'h0000_5A01) : v_din;
  end

  // Write logs and handshake sanity, sampled mid-cycle.
  int            cyc_cnt = 0;
  int            ready_viol = 0;
  logic [AW-1:0] va_q[$], wa_q[$];
  logic [WS-1:0] vd_q[$], wd_q[$];
  int            w_wen_cyc[$];
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) begin
    if (v_wen) begin va_q.push_back(v_addr); vd_q.push_back(v_din); end
    if (w_wen) begin wa_q.push_back(w_addr); wd_q.push_back(w_din); w_wen_cyc.push_back(cyc_cnt); end
    if (v_ready && (v_wen || !v_busy)) ready_viol++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  logic [WS-1:0] src_q[$];
  logic [WS-1:0] sent[$];

  task automatic fill(input int n, input bit seq);
    logic [WS-1:0] wd;
    src_q.delete();
    sent.delete();
    for (int k = 0; k < n; k++) begin
      wd = seq ? (32'h10 + 32'(k)) : $urandom();
      src_q.push_back(wd);
      sent.push_back(wd);
    end
  endtask

  // Reference: word k lands at {k / NI, k % NI} with the k-th streamed word.
  task automatic check_log(input string tag, input int sel, input int base, input int n);
    int            sz;
    logic [AW-1:0] ea;
    sz = (sel == 0) ? va_q.size() : wa_q.size();
    check({tag, "_nwrites"}, 64'(sz - base), 64'(n));
    for (int k = 0; k < n; k++) begin
      if (base + k < sz) begin
        ea = AW'(((k / NI) << 10) | (k % NI));
        check({tag, "_addr"}, (sel == 0) ? va_q[base + k] : wa_q[base + k], ea);
        check({tag, "_data"}, (sel == 0) ? vd_q[base + k] : wd_q[base + k], sent[k]);
      end
    end
  endtask

  // Runs one load: start pulse, stream feed (mode 0 always valid, 1 every other
  // cycle, 2 random), optional ignored start at cycle start_at, optional reset
  // asserted when the stop_wen-th write is seen. done_cyc = edges after start.
  task automatic run(input int sel, input int mode, input int start_at,
                     input int stop_wen, output int done_cyc);
    int   wen_seen;
    logic vld, acc, rdy;
    done_cyc = -1;
    wen_seen = 0;
    @(negedge clk);
    start_v = (sel == 0);
    start_w = (sel == 1);
    check("busy_before_start", (sel == 0) ? v_busy : w_busy, 0);
    @(posedge clk); #1;
    check("busy_rise", (sel == 0) ? v_busy : w_busy, 1);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      start_v = (sel == 0) && (cyc == start_at);
      start_w = (sel == 1) && (cyc == start_at);
      vld = (src_q.size() > 0) &&
            (mode == 0 || (mode == 1 && (cyc % 2) == 1) ||
             (mode == 2 && $urandom_range(0, 2) != 0));
      valid_v = (sel == 0) && vld;
      valid_w = (sel == 1) && vld;
      s_data  = (src_q.size() > 0) ? src_q[0] : '0;
      w_dout  = $urandom();
      rdy = (sel == 0) ? v_ready : w_ready;
      acc = vld && rdy;
      @(posedge clk);
      if (acc) void'(src_q.pop_front());
      #1;
      if ((sel == 0) ? v_wen : w_wen) begin
        wen_seen++;
        if (wen_seen == stop_wen) begin
          rst = 1'b0;
          valid_v = 1'b0; valid_w = 1'b0; start_v = 1'b0; start_w = 1'b0;
          return;
        end
      end
      if ((sel == 0) ? v_done : w_done) begin
        done_cyc = cyc;
        check("busy_at_done", (sel == 0) ? v_busy : w_busy, 1);
        break;
      end
    end
    valid_v = 1'b0; valid_w = 1'b0; start_v = 1'b0; start_w = 1'b0;
    if (done_cyc > 0) begin
      @(posedge clk); #1;
      check("busy_fall", (sel == 0) ? v_busy : w_busy, 0);
      check("done_pulse", (sel == 0) ? v_done : w_done, 0);
    end
  endtask

  initial begin
    int dc, vb, wb, vv;
    rst = 1'b0; start_v = 1'b0; start_w = 1'b0; valid_v = 1'b0; valid_w = 1'b0;
    s_data = '0; w_dout = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_s_ready", v_ready, 0);
    check("rst_mem_wen", v_wen, 0);
    check("rst_busy", v_busy, 0);
    check("rst_done", v_done, 0);
    check("rst_error", v_error, 0);
    check("rst_mem_addr", v_addr, 0);
    check("rst_mem_din", v_din, 0);
    check("rst_err_count", v_err_count, 0);
    check("rst_err_addr", v_err_addr, 0);
    check("rst_w_busy", w_busy, 0);
    @(negedge clk) rst = 1'b1;

    // Sequential words 0x10..0x17, stream always valid.
    fill(8, 1'b1); vb = va_q.size(); vv = ready_viol;
    run(0, 0, 0, 0, dc);
    check("A_done_cycle", 64'(dc), 64'(32));
    check_log("A", 0, vb, 8);
    check("A_error", v_error, 0);
    check("A_err_count", v_err_count, 0);

    // Toggling s_valid plus one surplus word that must stay unconsumed.
    fill(9, 1'b0); vb = va_q.size();
    run(0, 1, 0, 0, dc);
    check("B_done_seen", dc > 0, 1);
    check_log("B", 0, vb, 8);
    check("B_words_left", 64'(src_q.size()), 64'(1));
    check("B_ready_outside_accept", 64'(ready_viol - vv), 0);

    // RAM corrupts 0x402 and 0x403; random stream gaps.
    corrupt = 1'b1;
    fill(8, 1'b0); vb = va_q.size();
    run(0, 2, 0, 0, dc);
    corrupt = 1'b0;
    check("C_done_seen", dc > 0, 1);
    check_log("C", 0, vb, 8);
    check("C_error", v_error, 1);
    check("C_err_count", v_err_count, 2);
    check("C_err_addr", v_err_addr, 28'h402);
    repeat (3) @(posedge clk); #1;
    check("C_error_hold", v_error, 1);
    check("C_err_count_hold", v_err_count, 2);

    // Start pulsed mid-load is ignored; fresh start clears the error state.
    fill(8, 1'b0); vb = va_q.size();
    run(0, 0, 10, 0, dc);
    check("F_done_cycle", 64'(dc), 64'(32));
    check_log("F", 0, vb, 8);
    check("F_error", v_error, 0);
    check("F_err_count", v_err_count, 0);
    check("F_err_addr", v_err_addr, 0);

    // Write-only instance: a write every second cycle, mem_dout ignored.
    fill(4, 1'b0); wb = wa_q.size();
    run(1, 0, 0, 0, dc);
    check("D_done_cycle", 64'(dc), 64'(8));
    check_log("D", 1, wb, 4);
    for (int i = 1; i < w_wen_cyc.size() - wb; i++)
      check("D_wen_spacing", 64'(w_wen_cyc[wb + i] - w_wen_cyc[wb + i - 1]), 64'(2));
    check("D_error", w_error, 0);

    // Reset asserted during the third write, then a clean reload.
    fill(8, 1'b0);
    run(0, 0, 0, 3, dc);
    #1;
    check("E_wen_async", v_wen, 0);
    check("E_busy_async", v_busy, 0);
    check("E_ready_async", v_ready, 0);
    check("E_done_async", v_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fill(8, 1'b0); vb = va_q.size();
    run(0, 0, 0, 0, dc);
    check("E_done_cycle", 64'(dc), 64'(32));
    check_log("E", 0, vb, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
